// File: rtl/fb_rect_fill_if.sv
// SDRAM arbiter client port used by the rectangle-fill engine.
// The engine drives single-word write commands; the arbiter returns
// ready for command acceptance and one ack per completed write.
interface fb_rect_fill_if #(
    parameter int ADDR_W = 24
);
    logic              sdram_cmd_valid;
    logic              sdram_cmd_ready;
    logic              sdram_wr;
    logic [ADDR_W-1:0] sdram_addr_x16;
    logic [15:0]       sdram_wdata;
    logic [1:0]        sdram_wmask;
    logic              sdram_ack;

    // Engine side: issues write commands, observes ready and acks.
    modport master (
        output sdram_cmd_valid,
        output sdram_wr,
        output sdram_addr_x16,
        output sdram_wdata,
        output sdram_wmask,
        input  sdram_cmd_ready,
        input  sdram_ack
    );

    // Arbiter side: accepts commands and reports completions.
    modport slave (
        input  sdram_cmd_valid,
        input  sdram_wr,
        input  sdram_addr_x16,
        input  sdram_wdata,
        input  sdram_wmask,
        output sdram_cmd_ready,
        output sdram_ack
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Framebuffer rectangle-fill engine.
// Paints a width x height rectangle of 16-bit pixels starting at a base
// word address, stepping rows by a pitch. Writes are pipelined: up to
// MAX_PENDING commands may be accepted but not yet acknowledged. Once all
// writes are acknowledged a single-cycle done strobe is raised.
module fb_rect_fill #(
    parameter int ADDR_W      = 24,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [10:0]       width_i,
    input  logic [9:0]        height_i,
    input  logic [11:0]       pitch_i,
    input  logic [15:0]       color_i,
    input  logic [1:0]        wmask_i,
    output logic              busy_o,
    output logic              done_o,
    fb_rect_fill_if.master    sdram
);

    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [10:0]       x_q;
    logic [9:0]        y_q;
    logic [ADDR_W-1:0] row_addr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [10:0]       width_q;
    logic [9:0]        height_q;
    logic [11:0]       pitch_q;
    logic [15:0]       color_q;
    logic [1:0]        wmask_q;
    logic [3:0]        pending_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              ack_eff;
    logic              last_col;
    logic              last_row;
    logic [3:0]        pending_d;
    logic [ADDR_W-1:0] next_row_addr;

    // Handshake decode and next value of the outstanding-write counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        accept        = valid_q & sdram.sdram_cmd_ready;
        // An ack with nothing outstanding is a protocol error and is dropped.
        ack_eff       = sdram.sdram_ack & (pending_q != 4'd0);
        last_col      = (x_q == width_q - 11'd1);
        last_row      = (y_q == height_q - 10'd1);
        next_row_addr = row_addr_q + ADDR_W'(pitch_q);
        pending_d     = pending_q;
        if (accept && !ack_eff) begin
            pending_d = pending_q + 4'd1;
        end else if (!accept && ack_eff) begin
            pending_d = pending_q - 4'd1;
        end
    end

    // Control FSM, pixel walker and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: all datapath registers are reset too, so every output reads 0 during and after reset.
        if (rst_i) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            row_addr_q <= '0;
            addr_q     <= '0;
            width_q    <= '0;
            height_q   <= '0;
            pitch_q    <= '0;
            color_q    <= '0;
            wmask_q    <= '0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates from pre-edge values.
            pending_q <= pending_d;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        width_q    <= width_i;
                        height_q   <= height_i;
                        pitch_q    <= pitch_i;
                        color_q    <= color_i;
                        wmask_q    <= wmask_i;
                        x_q        <= '0;
                        y_q        <= '0;
                        row_addr_q <= base_addr_i;
                        addr_q     <= base_addr_i;
                        if ((width_i == 11'd0) || (height_i == 10'd0)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            busy_q  <= 1'b1;
                            valid_q <= (pending_d < MAX_P);
                        end
                    end
                end

                S_ISSUE: begin
                    if (accept) begin
                        if (last_col) begin
                            // Row wrap: step row base by pitch with no bubble.
                            x_q        <= '0;
                            y_q        <= y_q + 10'd1;
                            row_addr_q <= next_row_addr;
                            addr_q     <= next_row_addr;
                            if (last_row) begin
                                state_q <= S_DRAIN;
                                valid_q <= 1'b0;
                            end else begin
                                valid_q <= (pending_d < MAX_P);
                            end
                        end else begin
                            x_q     <= x_q + 11'd1;
                            addr_q  <= addr_q + ADDR_W'(1);
                            valid_q <= (pending_d < MAX_P);
                        end
                    end else begin
                        // Stalled or throttled: address/data held, valid
                        // follows the outstanding-write budget.
                        valid_q <= (pending_d < MAX_P);
                    end
                end

                S_DRAIN: begin
                    if (pending_d == 4'd0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign sdram.sdram_cmd_valid = valid_q;
    assign sdram.sdram_wr        = valid_q;
    assign sdram.sdram_addr_x16  = addr_q;
    assign sdram.sdram_wdata     = color_q;
    assign sdram.sdram_wmask     = wmask_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: the expected write stream of each
// fill is computed from base + y*pitch + x and queued; a monitor pops and
// compares on every accepted command. Acks are returned by a delayed model.
module tb_fb_rect_fill;

    localparam int ADDR_W      = 24;
    localparam int MAX_PENDING = 4;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } exp_t;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        start_i     = 1'b0;
    logic [23:0] base_addr_i = '0;
    logic [10:0] width_i     = '0;
    logic [9:0]  height_i    = '0;
    logic [11:0] pitch_i     = '0;
    logic [15:0] color_i     = '0;
    logic [1:0]  wmask_i     = '0;
    logic        busy_o;
    logic        done_o;

    fb_rect_fill_if #(.ADDR_W(ADDR_W)) bus ();

    fb_rect_fill #(
        .ADDR_W      (ADDR_W),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .width_i     (width_i),
        .height_i    (height_i),
        .pitch_i     (pitch_i),
        .color_i     (color_i),
        .wmask_i     (wmask_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sdram       (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;
    exp_t        exp_q[$];
    int unsigned ack_due_q[$];
    int          acc_cnt   = 0;
    int          ack_cnt   = 0;
    int          done_cnt  = 0;
    bit          ready_rand = 1'b0;
    bit          ack_en     = 1'b1;
    int          ack_delay  = 2;
    int          fill_acc0  = 0;
    int          fill_done0 = 0;
    int          fill_n     = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Arbiter model: drives ready and returns acks after ack_delay cycles.
    initial begin
        bus.sdram_cmd_ready = 1'b0;
        bus.sdram_ack       = 1'b0;
        forever begin
            @(negedge clk_i);
            if (ack_en && ack_due_q.size() > 0 && ack_due_q[0] <= cyc) begin
                bus.sdram_ack = 1'b1;
                void'(ack_due_q.pop_front());
            end else begin
                bus.sdram_ack = 1'b0;
            end
            bus.sdram_cmd_ready = ready_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    // Monitor: scoreboard compare, stall stability, completion bookkeeping.
    initial begin
        bit          stall_prev = 1'b0;
        logic [23:0] prev_addr  = '0;
        logic [15:0] prev_data  = '0;
        logic [1:0]  prev_mask  = '0;
        exp_t        e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_i) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", bus.sdram_cmd_valid, 1);
                    check("stall_addr", bus.sdram_addr_x16, prev_addr);
                    check("stall_data", bus.sdram_wdata, prev_data);
                    check("stall_mask", bus.sdram_wmask, prev_mask);
                end
                if (bus.sdram_wr != bus.sdram_cmd_valid) begin
                    check("wr_eq_valid", bus.sdram_wr, bus.sdram_cmd_valid);
                end
                if (bus.sdram_cmd_valid && bus.sdram_cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", bus.sdram_addr_x16, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_addr", bus.sdram_addr_x16, e.addr);
                        check("cmd_data", bus.sdram_wdata, e.data);
                        check("cmd_mask", bus.sdram_wmask, e.mask);
                    end
                    acc_cnt++;
                    ack_due_q.push_back(cyc + ack_delay);
                end
                if (bus.sdram_ack) ack_cnt++;
                if (done_o) begin
                    done_cnt++;
                    check("done_busy", busy_o, 0);
                    check("done_all_acked", ack_cnt, acc_cnt);
                    check("done_queue_empty", exp_q.size(), 0);
                end
                stall_prev = bus.sdram_cmd_valid && !bus.sdram_cmd_ready;
                prev_addr  = bus.sdram_addr_x16;
                prev_data  = bus.sdram_wdata;
                prev_mask  = bus.sdram_wmask;
            end
        end
    end

    // Queue the expected stream, pulse start, check the first cycle after.
    task automatic start_fill(input logic [23:0] base, input int w, input int h,
                              input int pitch, input logic [15:0] color,
                              input logic [1:0] mask);
        exp_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.addr = 24'(int'(base) + y * pitch + x);
                e.data = color;
                e.mask = mask;
                exp_q.push_back(e);
            end
        end
        @(negedge clk_i);
        fill_acc0   = acc_cnt;
        fill_done0  = done_cnt;
        fill_n      = w * h;
        start_i     = 1'b1;
        base_addr_i = base;
        width_i     = 11'(w);
        height_i    = 10'(h);
        pitch_i     = 12'(pitch);
        color_i     = color;
        wmask_i     = mask;
        @(negedge clk_i);
        start_i = 1'b0;
        #3;
        if (w == 0 || h == 0) begin
            check("degen_done_n1", done_o, 1);
            check("degen_busy_n1", busy_o, 0);
            check("degen_valid_n1", bus.sdram_cmd_valid, 0);
        end else begin
            check("start_busy_n1", busy_o, 1);
            check("start_valid_n1", bus.sdram_cmd_valid, 1);
            check("start_addr_n1", bus.sdram_addr_x16, base);
        end
    endtask

    // Random start pulse while the engine is busy; must be ignored.
    task automatic poke_start();
        @(negedge clk_i);
        start_i     = 1'b1;
        base_addr_i = 24'($urandom);
        width_i     = 11'($urandom_range(1, 9));
        height_i    = 10'($urandom_range(1, 9));
        pitch_i     = 12'($urandom);
        color_i     = 16'($urandom);
        wmask_i     = 2'($urandom);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Wait (bounded) for done, then check totals; optionally start in DONE.
    task automatic wait_done(input bit poke_in_done);
        int t = 0;
        while (done_cnt == fill_done0 && t < 3000) begin
            @(negedge clk_i);
            #3;
            t++;
        end
        check("done_timeout", (t < 3000) ? 1 : 0, 1);
        check("done_count", done_cnt - fill_done0, 1);
        check("accept_count", acc_cnt - fill_acc0, fill_n);
        if (poke_in_done) begin
            start_i  = 1'b1;
            width_i  = 11'd1;
            height_i = 10'd1;
            @(negedge clk_i);
            start_i = 1'b0;
            #3;
            check("start_in_done_busy", busy_o, 0);
            check("start_in_done_valid", bus.sdram_cmd_valid, 0);
        end else begin
            @(negedge clk_i);
            #3;
            check("after_done_busy", busy_o, 0);
            check("done_one_cycle", done_o, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2;
        check("rst_valid", bus.sdram_cmd_valid, 0);
        check("rst_wr", bus.sdram_wr, 0);
        check("rst_addr", bus.sdram_addr_x16, 0);
        check("rst_wdata", bus.sdram_wdata, 0);
        check("rst_wmask", bus.sdram_wmask, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Basic 4x2 fill.
        ready_rand = 1'b0;
        ack_delay  = 2;
        start_fill(24'h000100, 4, 2, 640, 16'hF800, 2'b11);
        wait_done(1'b0);

        // Random backpressure, random geometry and ack latency.
        for (int i = 0; i < 6; i++) begin
            ready_rand = 1'b1;
            ack_delay  = $urandom_range(1, 6);
            start_fill(24'($urandom), $urandom_range(1, 6), $urandom_range(1, 4),
                       $urandom_range(0, 4095), 16'($urandom), 2'($urandom));
            if (i == 0) begin
                repeat (2) @(negedge clk_i);
                poke_start();
            end
            wait_done(1'b0);
        end

        // Throttling: 1x10, acks withheld for 20 cycles.
        ready_rand = 1'b0;
        ack_en     = 1'b0;
        ack_delay  = 1;
        start_fill(24'h002000, 10, 1, 0, 16'h1234, 2'b01);
        repeat (20) @(negedge clk_i);
        #3;
        check("throttle_accepts", acc_cnt - fill_acc0, MAX_PENDING);
        check("throttle_valid_low", bus.sdram_cmd_valid, 0);
        ack_en = 1'b1;
        t = 0;
        do begin
            @(negedge clk_i);
            #3;
            t++;
        end while (!bus.sdram_ack && t < 10);
        check("throttle_ack_seen", bus.sdram_ack, 1);
        check("throttle_valid_in_ack_cycle", bus.sdram_cmd_valid, 0);
        @(negedge clk_i);
        #3;
        check("throttle_valid_after_ack", bus.sdram_cmd_valid, 1);
        wait_done(1'b0);

        // Degenerate sizes.
        ack_delay = 2;
        start_fill(24'h000500, 0, 3, 10, 16'h5555, 2'b11);
        wait_done(1'b0);
        start_fill(24'h000600, 3, 0, 10, 16'h5555, 2'b11);
        wait_done(1'b1);

        // Back-to-back: start in the cycle right after DONE, then wrap.
        start_fill(24'h000700, 2, 2, 4, 16'h0F0F, 2'b10);
        wait_done(1'b0);
        start_fill(24'hFFFFFE, 4, 1, 0, 16'hCAFE, 2'b11);
        wait_done(1'b0);

        // Reset mid-fill after 3 accepts.
        ack_delay = 8;
        start_fill(24'h001234, 5, 3, 100, 16'hABCD, 2'b10);
        t = 0;
        do begin
            @(posedge clk_i);
            #1;
            t++;
        end while ((acc_cnt - fill_acc0) < 3 && t < 50);
        rst_i = 1'b1;
        exp_q.delete();
        ack_due_q.delete();
        #1;
        check("midrst_accepts", acc_cnt - fill_acc0, 3);
        check("midrst_valid", bus.sdram_cmd_valid, 0);
        check("midrst_wr", bus.sdram_wr, 0);
        check("midrst_addr", bus.sdram_addr_x16, 0);
        check("midrst_wdata", bus.sdram_wdata, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        ack_cnt = acc_cnt;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check("midrst_no_done", done_cnt, fill_done0);
        ack_delay = 3;
        start_fill(24'h004000, 3, 2, 16, 16'h7E7E, 2'b01);
        wait_done(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Framebuffer rectangle-fill engine: a write-only SDRAM client that paints a 2-D rectangle of 16-bit pixels into the framebuffer. It is the counterpart of the video controller's framebuffer reader. It is started by CSR-driven parameters and issues pipelined single-word write commands through an arbiter client port. It signals completion with a one-cycle `done_o` strobe, which is routed to the interrupt controller.

## Interface
Parameters:
- `ADDR_W`, 24, SDRAM word (x16) address width.
- `MAX_PENDING`, 4, maximum accepted-but-unacknowledged writes (1..15).

Ports:
- `clk_i` in 1: system clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: start strobe; parameters are sampled in the same cycle.
- `base_addr_i` in ADDR_W: word address of the top-left pixel.
- `width_i` in 11: pixels per row.
- `height_i` in 10: row count.
- `pitch_i` in 12: row stride in words.
- `color_i` in 16: fill value.
- `wmask_i` in 2: byte enables, passed to `sdram_wmask`.
- `busy_o` out 1: high from the cycle after an accepted start until the done cycle.
- `done_o` out 1: one-cycle completion strobe.
- `sdram_cmd_valid` out 1: write command valid.
- `sdram_cmd_ready` in 1: arbiter accepts the command when it is high together with valid.
- `sdram_wr` out 1: equals `sdram_cmd_valid`.
- `sdram_addr_x16` out ADDR_W: write word address.
- `sdram_wdata` out 16: write data.
- `sdram_wmask` out 2: byte mask.
- `sdram_ack` in 1: one pulse per completed write, in acceptance order.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset clears the state to IDLE and zeroes all counters.
- State IDLE:
  - A `start_i` pulse latches base, width, height, pitch, color and wmask.
  - If width or height is 0, the block goes to DONE.
  - Otherwise it goes to ISSUE with x=0, y=0, and row_addr=base.
- `start_i` outside IDLE is ignored and has no effect on the latched parameters.
- State ISSUE:
  - The command address is row_addr+x, truncated to ADDR_W bits. Wrap-around past 2^ADDR_W-1 to 0 is legal.
  - On acceptance (valid & ready):
    - if x<width-1: x increments;
    - otherwise x=0, y increments, and row_addr += pitch (modulo 2^ADDR_W).
  - On acceptance of the last pixel (x=width-1, y=height-1), the block goes to DRAIN.
  - Valid is asserted only while pending < MAX_PENDING; pending counts the writes already accepted and counted in that cycle.
- Pending counter:
  - +1 on acceptance, -1 on `sdram_ack`; acceptance and ack in the same cycle leave it unchanged.
  - An ack with pending=0 is a protocol error: it is ignored and the counter stays at 0.
- State DRAIN: waits for pending=0, then goes to DONE.
- State DONE (one cycle): `done_o`=1, `busy_o`=0, then IDLE.
  - A `start_i` in the DONE cycle is ignored.
  - A `start_i` in the cycle after DONE is accepted.
- An asynchronous reset mid-operation abandons the fill immediately:
  - `sdram_cmd_valid` drops asynchronously;
  - no `done_o` is produced;
  - acks still outstanding from the SDRAM are discarded.

## Timing
- Start accepted in cycle N:
  - `busy_o`=1 and `sdram_cmd_valid`=1 with the first address in N+1.
  - Degenerate size: `done_o` in N+1 and `busy_o` stays 0.
- While valid=1 and ready=0, address, data and mask are held stable.
- With ready held high and acks returning fast enough, one command is accepted per cycle. Row transitions insert no bubble.
- Throttling: if pending reaches MAX_PENDING at an acceptance in cycle k, valid is 0 in k+1. An ack in cycle j re-asserts valid in j+1.
- `done_o` occurs exactly 1 cycle after the cycle in which the final ack brings pending to 0 in DRAIN.
- Total commands issued = width*height, each address exactly once. Data = color and mask = wmask for every command.

## Test plan
- Basic 4x2 fill:
  - Stimulus: base=0x000100, pitch=640, color=0xF800, ready=1, acks 2 cycles after accept.
  - Required: addresses 0x100..0x103, then 0x380..0x383; 8 commands; one `done_o`; `busy_o` low after it.
- Backpressure: ready toggles randomly. Required: address, data and mask are stable while stalled; no duplicates and no skipped addresses.
- Throttling:
  - Stimulus: MAX_PENDING=4, acks withheld for 20 cycles, 1x10 fill.
  - Required: exactly 4 accepts, then valid=0 until the first ack; valid re-asserts 1 cycle later; `done_o` after the 10th ack.
- Degenerate and ignored starts:
  - width=0 → `done_o` 1 cycle after start, zero commands.
  - start while busy → no change in the command sequence.
- Wrap:
  - Stimulus: base=0xFFFFFE, width=4, height=1.
  - Required: addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Reset mid-fill:
  - Stimulus: assert `rst_i` after 3 accepts.
  - Required: all outputs are 0 asynchronously; no `done_o`; a subsequent fresh start completes normally.
